// File: rtl/spi_cmd_decoder.sv
// SPI mode-0 slave front end: oversampled byte assembly and packet decode
// into sprite RAM and display register write strobes.
module spi_cmd_decoder #(
  parameter int ADDR_W      = 16,
  parameter int REG_IDX_W   = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                 clk,
  input  logic                 reset_b,
  input  logic                 sck,
  input  logic                 mosi,
  output logic                 wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [7:0]           wr_data,
  output logic                 reg_we,
  output logic [REG_IDX_W-1:0] reg_idx,
  output logic [7:0]           reg_data,
  output logic                 rx_err
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_OPCODE,
    S_ADDR_HI,
    S_ADDR_LO,
    S_PIX_DATA,
    S_REG_IDX,
    S_REG_DATA,
    S_DISCARD
  } state_e;

  state_e               state_q;
  logic [2:0]           sck_q;
  logic [1:0]           mosi_q;
  logic [7:0]           shift_q, shift_d;
  logic [2:0]           bcnt_q, bcnt_d;
  logic                 done_q, done_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic [7:0]           hi_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [REG_IDX_W-1:0] idx_q;

  logic                 wr_en_q;
  logic [ADDR_W-1:0]    wr_addr_q;
  logic [7:0]           wr_data_q;
  logic                 reg_we_q;
  logic [REG_IDX_W-1:0] reg_idx_q;
  logic [7:0]           reg_data_q;
  logic                 rx_err_q;

  logic sck_rise;
  logic tmo_hit;
  logic tmo_err;
  logic mid_pkt;

  assign sck_rise = sck_q[1] & ~sck_q[2];

  // Fires once, on the cycle the idle counter would reach saturation.
  assign tmo_hit = !sck_rise &&
                   (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

  assign mid_pkt = (state_q == S_ADDR_HI) ||
                   (state_q == S_ADDR_LO) ||
                   (state_q == S_REG_IDX) ||
                   (state_q == S_REG_DATA);

  assign tmo_err = tmo_hit && ((bcnt_q != 3'd0) || mid_pkt);

  always_comb begin
    shift_d = shift_q;
    bcnt_d  = bcnt_q;
    done_d  = 1'b0;
    tmo_d   = tmo_q;
    if (sck_rise) begin
      shift_d = {shift_q[6:0], mosi_q[1]};
      bcnt_d  = bcnt_q + 3'd1;
      done_d  = (bcnt_q == 3'd7);
      tmo_d   = '0;
    end else begin
      if (tmo_q != TMO_W'(TIMEOUT_CYC))
        tmo_d = tmo_q + 1'b1;
      if (tmo_hit)
        bcnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q    <= S_OPCODE;
      sck_q      <= '0;
      mosi_q     <= '0;
      shift_q    <= '0;
      bcnt_q     <= '0;
      done_q     <= 1'b0;
      tmo_q      <= '0;
      hi_q       <= '0;
      addr_q     <= '0;
      idx_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      reg_we_q   <= 1'b0;
      reg_idx_q  <= '0;
      reg_data_q <= '0;
      rx_err_q   <= 1'b0;
    end else begin
      sck_q    <= {sck_q[1:0], sck};
      mosi_q   <= {mosi_q[0], mosi};
      shift_q  <= shift_d;
      bcnt_q   <= bcnt_d;
      done_q   <= done_d;
      tmo_q    <= tmo_d;
      wr_en_q  <= 1'b0;
      reg_we_q <= 1'b0;
      rx_err_q <= 1'b0;
      if (tmo_hit) begin
        state_q  <= S_OPCODE;
        rx_err_q <= tmo_err;
      end else if (done_q) begin
        unique case (state_q)
          S_OPCODE: begin
            if (shift_q == 8'h01) begin
              state_q <= S_ADDR_HI;
            end else if (shift_q == 8'h02) begin
              state_q <= S_REG_IDX;
            end else begin
              state_q  <= S_DISCARD;
              rx_err_q <= 1'b1;
            end
          end
          S_ADDR_HI: begin
            hi_q    <= shift_q;
            state_q <= S_ADDR_LO;
          end
          S_ADDR_LO: begin
            addr_q  <= ADDR_W'({hi_q, shift_q});
            state_q <= S_PIX_DATA;
          end
          S_PIX_DATA: begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= addr_q;
            wr_data_q <= shift_q;
            addr_q    <= addr_q + 1'b1;
          end
          S_REG_IDX: begin
            idx_q   <= shift_q[REG_IDX_W-1:0];
            state_q <= S_REG_DATA;
          end
          S_REG_DATA: begin
            reg_we_q   <= 1'b1;
            reg_idx_q  <= idx_q;
            reg_data_q <= shift_q;
            state_q    <= S_OPCODE;
          end
          S_DISCARD: begin
            state_q <= S_DISCARD;
          end
          default: begin
            state_q <= S_OPCODE;
          end
        endcase
      end
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign reg_we   = reg_we_q;
  assign reg_idx  = reg_idx_q;
  assign reg_data = reg_data_q;
  assign rx_err   = rx_err_q;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Bench for spi_cmd_decoder: packet-level reference model,
// randomized payloads, per-scenario checks.
`timescale 1ns/1ps
module tb_spi_cmd_decoder;

  localparam int ADDR_W    = 16;
  localparam int REG_IDX_W = 4;
  localparam int TMO       = 4096;

  typedef logic [7:0] byte_t;

  logic                 clk = 1'b0;
  logic                 reset_b = 1'b0;
  logic                 sck = 1'b0;
  logic                 mosi = 1'b0;
  logic                 wr_en;
  logic [ADDR_W-1:0]    wr_addr;
  logic [7:0]           wr_data;
  logic                 reg_we;
  logic [REG_IDX_W-1:0] reg_idx;
  logic [7:0]           reg_data;
  logic                 rx_err;

  spi_cmd_decoder #(
    .ADDR_W(ADDR_W),
    .REG_IDX_W(REG_IDX_W),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk),
    .reset_b(reset_b),
    .sck(sck),
    .mosi(mosi),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .reg_we(reg_we),
    .reg_idx(reg_idx),
    .reg_data(reg_data),
    .rx_err(rx_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [23:0] obs_wr[$];
  logic [23:0] exp_wr[$];
  logic [11:0] obs_reg[$];
  logic [11:0] exp_reg[$];
  int          lat_q[$];
  int          obs_err = 0;
  int          exp_err = 0;
  int          overlap = 0;
  int          wide = 0;
  logic        wr_prev = 1'b0;
  logic        reg_prev = 1'b0;
  time         last_rise_t = 0;

  always @(negedge clk) begin
    if (reset_b) begin
      if (wr_en) begin
        obs_wr.push_back({wr_addr, wr_data});
        lat_q.push_back(int'($time - last_rise_t));
      end
      if (reg_we) begin
        obs_reg.push_back({reg_idx, reg_data});
        lat_q.push_back(int'($time - last_rise_t));
      end
      if (wr_en && reg_we) overlap++;
      if ((wr_en && wr_prev) || (reg_we && reg_prev)) wide++;
      if (rx_err) obs_err++;
    end
    wr_prev  = wr_en;
    reg_prev = reg_we;
  end

  // Reference: walk the bytes of one frame (bytes between idle gaps).
  task automatic model_frame(input byte_t b[$], input int partial);
    int i;
    int n;
    int a;
    bit sens;
    i = 0;
    n = b.size();
    sens = 1'b0;
    while (i < n) begin
      if (b[i] == 8'h01) begin
        if (n - i < 3) begin
          sens = 1'b1;
        end else begin
          a = {b[i+1], b[i+2]};
          for (int k = i + 3; k < n; k++) begin
            exp_wr.push_back({a[15:0], b[k]});
            a = (a + 1) % 65536;
          end
        end
        i = n;
      end else if (b[i] == 8'h02) begin
        if (n - i < 3) begin
          sens = 1'b1;
          i = n;
        end else begin
          exp_reg.push_back({b[i+1][3:0], b[i+2]});
          i = i + 3;
        end
      end else begin
        exp_err++;
        i = n;
      end
    end
    if (sens || partial > 0) exp_err++;
  endtask

  task automatic clear_obs();
    obs_wr.delete();
    exp_wr.delete();
    obs_reg.delete();
    exp_reg.delete();
    lat_q.delete();
    obs_err = 0;
    exp_err = 0;
    overlap = 0;
    wide = 0;
  endtask

  task automatic send_bits(input byte_t b, input int n,
                           input int half, input bit rp);
    int ph;
    ph = rp ? int'($urandom_range(1, 9)) : 3;
    @(posedge clk);
    #(ph);
    for (int i = 7; i >= 8 - n; i--) begin
      mosi = b[i];
      #(half);
      sck = 1'b1;
      if (i == 0) last_rise_t = $time;
      #(half);
      sck = 1'b0;
    end
  endtask

  task automatic idle();
    repeat (TMO + 16) @(posedge clk);
  endtask

  task automatic send_frame(input byte_t b[$], input int partial,
                            input byte_t pb, input int half,
                            input bit rp);
    model_frame(b, partial);
    foreach (b[i]) send_bits(b[i], 8, half, rp);
    if (partial > 0) send_bits(pb, partial, half, rp);
    idle();
  endtask

  task automatic test_reset();
    byte_t f[$];
    logic [42:0] outs;
    clear_obs();
    send_bits(8'h02, 8, 50, 1'b0);
    send_bits(8'h0C, 8, 50, 1'b0);
    send_bits(8'h5A, 8, 50, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    vectors++;
    if ({reg_idx, reg_data} !== 12'hC5A) begin
      miscompares++;
      $display("FAIL reset_pre_reg: got %h expected c5a",
               {reg_idx, reg_data});
    end
    send_bits(8'hA0, 3, 50, 1'b0);
    @(posedge clk);
    #3 reset_b = 1'b0;
    #1;
    outs = {wr_en, wr_addr, wr_data, reg_we, reg_idx, reg_data, rx_err};
    vectors++;
    if (outs !== '0) begin
      miscompares++;
      $display("FAIL reset_async_outs: got %h expected 0", outs);
    end
    repeat (3) @(posedge clk);
    #2 reset_b = 1'b1;
    @(negedge clk);
    outs = {wr_en, wr_addr, wr_data, reg_we, reg_idx, reg_data, rx_err};
    vectors++;
    if (outs !== '0) begin
      miscompares++;
      $display("FAIL reset_release_outs: got %h expected 0", outs);
    end
    clear_obs();
    f = '{8'h02, 8'h05, 8'hA7};
    send_frame(f, 0, 8'h00, 50, 1'b0);
    vectors++;
    if (obs_reg.size() !== 1 || obs_wr.size() !== 0) begin
      miscompares++;
      $display("FAIL reset_next_count: got reg %0d wr %0d expected 1 0",
               obs_reg.size(), obs_wr.size());
    end
    for (int i = 0; i < obs_reg.size() && i < exp_reg.size(); i++) begin
      vectors++;
      if (obs_reg[i] !== exp_reg[i]) begin
        miscompares++;
        $display("FAIL reset_next_reg: got %h expected %h",
                 obs_reg[i], exp_reg[i]);
      end
    end
    vectors++;
    if (obs_err !== exp_err || wide !== 0) begin
      miscompares++;
      $display("FAIL reset_next_err: got err %0d wide %0d expected %0d 0",
               obs_err, wide, exp_err);
    end
  endtask

  task automatic test_pixel_burst();
    byte_t f[$];
    clear_obs();
    f = '{8'h01, 8'h12, 8'h34, 8'hFF, 8'h00, 8'h80};
    send_frame(f, 0, 8'h00, 50, 1'b1);
    vectors++;
    if (obs_wr.size() !== exp_wr.size() || obs_wr.size() !== 3) begin
      miscompares++;
      $display("FAIL burst_count: got %0d expected %0d",
               obs_wr.size(), exp_wr.size());
    end
    for (int i = 0; i < obs_wr.size() && i < exp_wr.size(); i++) begin
      vectors++;
      if (obs_wr[i] !== exp_wr[i]) begin
        miscompares++;
        $display("FAIL burst_wr%0d: got %h expected %h",
                 i, obs_wr[i], exp_wr[i]);
      end
    end
    foreach (lat_q[i]) begin
      vectors++;
      if (lat_q[i] < 30 || lat_q[i] > 55) begin
        miscompares++;
        $display("FAIL burst_latency%0d: got %0d ns expected 30..55",
                 i, lat_q[i]);
      end
    end
    vectors++;
    if (obs_err !== 0 || overlap !== 0 || wide !== 0) begin
      miscompares++;
      $display("FAIL burst_err: got err %0d ovl %0d wide %0d expected 0",
               obs_err, overlap, wide);
    end
  endtask

  task automatic test_wrap();
    byte_t f[$];
    clear_obs();
    f = '{8'h01, 8'hFF, 8'hFF, 8'h11, 8'h22};
    send_frame(f, 0, 8'h00, 50, 1'b1);
    vectors++;
    if (obs_wr.size() !== exp_wr.size()) begin
      miscompares++;
      $display("FAIL wrap_count: got %0d expected %0d",
               obs_wr.size(), exp_wr.size());
    end
    for (int i = 0; i < obs_wr.size() && i < exp_wr.size(); i++) begin
      vectors++;
      if (obs_wr[i] !== exp_wr[i]) begin
        miscompares++;
        $display("FAIL wrap_wr%0d: got %h expected %h",
                 i, obs_wr[i], exp_wr[i]);
      end
    end
    vectors++;
    if (obs_err !== exp_err) begin
      miscompares++;
      $display("FAIL wrap_err: got %0d expected %0d", obs_err, exp_err);
    end
  endtask

  task automatic test_bad_opcode();
    byte_t f[$];
    clear_obs();
    f = '{8'h7E, 8'h01, 8'h00, 8'h00, 8'h55};
    send_frame(f, 0, 8'h00, 50, 1'b1);
    vectors++;
    if (obs_err !== exp_err || obs_err !== 1) begin
      miscompares++;
      $display("FAIL badop_err: got %0d expected %0d", obs_err, exp_err);
    end
    vectors++;
    if (obs_wr.size() !== 0 || obs_reg.size() !== 0) begin
      miscompares++;
      $display("FAIL badop_strobes: got wr %0d reg %0d expected 0 0",
               obs_wr.size(), obs_reg.size());
    end
    clear_obs();
    f = '{8'h02, 8'h03, 8'h09};
    send_frame(f, 0, 8'h00, 50, 1'b1);
    vectors++;
    if (obs_reg.size() !== 1 || obs_err !== 0) begin
      miscompares++;
      $display("FAIL badop_next: got reg %0d err %0d expected 1 0",
               obs_reg.size(), obs_err);
    end
    for (int i = 0; i < obs_reg.size() && i < exp_reg.size(); i++) begin
      vectors++;
      if (obs_reg[i] !== exp_reg[i]) begin
        miscompares++;
        $display("FAIL badop_next_reg: got %h expected %h",
                 obs_reg[i], exp_reg[i]);
      end
    end
  endtask

  task automatic test_truncation();
    byte_t f[$];
    clear_obs();
    f = '{8'h01, 8'h00};
    send_frame(f, 5, 8'($urandom), 50, 1'b1);
    vectors++;
    if (obs_err !== exp_err || obs_err !== 1) begin
      miscompares++;
      $display("FAIL trunc_err: got %0d expected %0d", obs_err, exp_err);
    end
    vectors++;
    if (obs_wr.size() !== 0) begin
      miscompares++;
      $display("FAIL trunc_wr: got %0d expected 0", obs_wr.size());
    end
    clear_obs();
    f = '{8'h01, 8'($urandom), 8'($urandom),
          8'($urandom), 8'($urandom), 8'($urandom)};
    send_frame(f, 0, 8'h00, 50, 1'b1);
    vectors++;
    if (obs_wr.size() !== exp_wr.size() || obs_err !== exp_err) begin
      miscompares++;
      $display("FAIL trunc_next: got wr %0d err %0d expected %0d %0d",
               obs_wr.size(), obs_err, exp_wr.size(), exp_err);
    end
    for (int i = 0; i < obs_wr.size() && i < exp_wr.size(); i++) begin
      vectors++;
      if (obs_wr[i] !== exp_wr[i]) begin
        miscompares++;
        $display("FAIL trunc_next_wr%0d: got %h expected %h",
                 i, obs_wr[i], exp_wr[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    byte_t f[$];
    clear_obs();
    for (int p = 0; p < 8; p++) begin
      f.push_back(8'h02);
      f.push_back(8'($urandom));
      f.push_back(8'($urandom));
    end
    send_frame(f, 0, 8'h00, 50, 1'b1);
    vectors++;
    if (obs_reg.size() !== exp_reg.size() || obs_err !== exp_err) begin
      miscompares++;
      $display("FAIL b2b_count: got reg %0d err %0d expected %0d %0d",
               obs_reg.size(), obs_err, exp_reg.size(), exp_err);
    end
    for (int i = 0; i < obs_reg.size() && i < exp_reg.size(); i++) begin
      vectors++;
      if (obs_reg[i] !== exp_reg[i]) begin
        miscompares++;
        $display("FAIL b2b_reg%0d: got %h expected %h",
                 i, obs_reg[i], exp_reg[i]);
      end
    end
  endtask

  task automatic test_timing_margin();
    byte_t f[$];
    clear_obs();
    f.push_back(8'h01);
    f.push_back(8'($urandom));
    f.push_back(8'($urandom));
    for (int i = 0; i < 256; i++) f.push_back(8'($urandom));
    send_frame(f, 0, 8'h00, 40, 1'b1);
    vectors++;
    if (obs_wr.size() !== 256 || exp_wr.size() !== 256) begin
      miscompares++;
      $display("FAIL margin_count: got %0d expected %0d",
               obs_wr.size(), exp_wr.size());
    end
    for (int i = 0; i < obs_wr.size() && i < exp_wr.size(); i++) begin
      vectors++;
      if (obs_wr[i] !== exp_wr[i]) begin
        miscompares++;
        $display("FAIL margin_wr%0d: got %h expected %h",
                 i, obs_wr[i], exp_wr[i]);
      end
    end
    vectors++;
    if (obs_err !== 0 || overlap !== 0 || wide !== 0) begin
      miscompares++;
      $display("FAIL margin_err: got err %0d ovl %0d wide %0d expected 0",
               obs_err, overlap, wide);
    end
  endtask

  initial begin
    reset_b = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_b = 1'b1;
    test_reset();
    test_pixel_burst();
    test_wrap();
    test_bad_opcode();
    test_truncation();
    test_back_to_back();
    test_timing_margin();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_cmd_decoder.md
Name: spi_cmd_decoder

Overview:
- SPI slave front end between the microcontroller and the sprite/game-state storage that feeds videoGen.
- Oversamples sck/mosi in the system clock domain and assembles bytes MSB-first, SPI mode 0.
- Decodes a small packet protocol into single-cycle write strobes for the sprite pixel RAM and a 16-entry display register file (health values, menu cursor, sprite select).
- There is no chip-select; packet framing is recovered from an sck idle timeout.

Parameters:
- ADDR_W, 16, sprite RAM address width; the address wraps modulo 2^ADDR_W.
- REG_IDX_W, 4, display register index width.
- TIMEOUT_CYC, 4096, number of clk cycles with no sck rising edge after which framing resets.

Ports:
- clk, input, 1, system clock; sck must be at most clk/8.
- reset_b, input, 1, asynchronous active-low reset.
- sck, input, 1, SPI clock from the MCU, asynchronous to clk.
- mosi, input, 1, SPI data from the MCU, asynchronous to clk.
- wr_en, output, 1, one-cycle sprite RAM write strobe.
- wr_addr, output, ADDR_W, sprite RAM write address; valid when wr_en is high.
- wr_data, output, 8, sprite RAM write data; valid when wr_en is high.
- reg_we, output, 1, one-cycle display register write strobe.
- reg_idx, output, REG_IDX_W, display register index.
- reg_data, output, 8, display register data.
- rx_err, output, 1, one-cycle pulse on a protocol error.

Behaviour:
- Reset: all outputs are 0; FSM is in OPCODE; bit counter, shift register, address and timeout counter are cleared. Reset takes effect immediately, including mid-byte or mid-packet.
- Sync: sck and mosi each pass through two flops; a third sck flop provides rising-edge detection (sck_rise).
- Byte assembly: on each sck_rise, shift the synchronized mosi in MSB-first and increment the 3-bit counter. On the 8th bit, assert internal byte_done with the completed byte.
- Latency: any strobe is registered and goes high in the clk cycle after byte_done, for exactly one cycle. Pin-edge to strobe is 4 clk cycles ±1 (synchronizer phase).
- Timeout counter: clears on every sck_rise and saturates at TIMEOUT_CYC.
  - On reaching TIMEOUT_CYC, the bit counter clears and the FSM returns to OPCODE.
  - rx_err pulses only if the bit counter was nonzero, or the FSM was in ADDR_HI, ADDR_LO, REG_IDX or REG_DATA.
  - No pulse from OPCODE, PIX_DATA or DISCARD.
- FSM transitions (each on byte_done):
  - OPCODE: 0x01 goes to ADDR_HI. 0x02 goes to REG_IDX. Any other value goes to DISCARD with an rx_err pulse.
  - ADDR_HI: latch the high byte, go to ADDR_LO.
  - ADDR_LO: latch the low byte; addr = {hi, lo} truncated to ADDR_W bits; go to PIX_DATA.
  - PIX_DATA: wr_en=1, wr_addr=addr, wr_data=byte; then addr increments, wrapping from 2^ADDR_W-1 to 0. The FSM stays in PIX_DATA until timeout, so a packet may carry an unbounded number of data bytes.
  - REG_IDX: latch byte[REG_IDX_W-1:0]; the upper bits are ignored; go to REG_DATA.
  - REG_DATA: reg_we=1, reg_idx=latched index, reg_data=byte; go to OPCODE, so back-to-back register packets need no gap.
  - DISCARD: ignore all bytes until timeout.
- Simultaneous events:
  - The timeout and sck_rise cannot coincide, because sck_rise clears the counter, and sck_rise takes priority.
  - wr_en and reg_we are never high in the same cycle.
- Held values: wr_addr, wr_data, reg_idx and reg_data keep their last value when the strobes are low.

Test Plan:
- Reset: reset_b low mid-byte, then released. All outputs read 0. Next byte 0x02, 0x05, 0xA7 gives reg_we for one cycle with reg_idx=5, reg_data=0xA7.
- Pixel burst: 0x01, 0x12, 0x34, 0xFF, 0x00, 0x80. Three wr_en pulses at addr 0x1234/0x1235/0x1236 with data 0xFF/0x00/0x80, each 4±1 clk after the 8th sck edge. No rx_err.
- Wrap: 0x01, 0xFF, 0xFF, 0x11, 0x22 gives writes at 0xFFFF then 0x0000.
- Bad opcode: 0x7E, 0x01, 0x00, 0x00, 0x55 gives one rx_err and no strobes. After a ≥TIMEOUT_CYC gap, 0x02, 0x03, 0x09 is accepted (reg 3 = 0x09).
- Truncation: 0x01, 0x00 then 5 bits, then idle TIMEOUT_CYC. Exactly one rx_err and no wr_en; the next packet decodes normally.
- Timing margin: sck at clk/8 with random phase, 256-byte pixel burst. All 256 writes have the correct address and data against the reference model.
